// File: rtl/lspc_irq_timer_ctrl.sv
// LSPC timer configuration and interrupt controller (68k register window, IRQ latch, nIPL).
// Optional readback mux: define LSPC_IRQ_READBACK_EN to add the RD_DATA output.
module lspc_irq_timer_ctrl #(
    parameter int AA_W    = 8,
    parameter bit IRQ_RST = 1'b1
) (
    input  logic            CLK,
    input  logic            nRESETP,
    input  logic [2:0]      M68K_ADDR,
    input  logic [15:0]     M68K_DATA,
    input  logic            M68K_nUDS,
    input  logic            M68K_nLDS,
    input  logic            nLSPWE,
    input  logic            VBL_IRQ,
    input  logic            TIMER_IRQ,
    output logic            WR_TIMER_HIGH,
    output logic            WR_TIMER_LOW,
    output logic [2:0]      TIMER_MODE,
    output logic            TIMER_IRQ_EN,
    output logic            AA_DISABLE,
    output logic [AA_W-1:0] AA_SPEED,
    output logic            TIMER_STOP,
    output logic [2:0]      IRQ_PEND,
    output logic [2:0]      nIPL
`ifdef LSPC_IRQ_READBACK_EN
    ,
    output logic [15:0]     RD_DATA
`endif
);

    logic            r_we_q;
    logic            r_acc;
    logic [2:0]      r_addr;
    logic [15:0]     r_data;
    logic            r_nuds;
    logic            r_nlds;
    logic            r_wr_hi;
    logic            r_wr_lo;
    logic [2:0]      r_mode;
    logic            r_irq_en;
    logic            r_aa_dis;
    logic [AA_W-1:0] r_aa_speed;
    logic            r_stop;
    logic [2:0]      r_pend;
    logic            r_tirq_q;
    logic [2:0]      r_nipl;

    logic            w_accept;
    logic            w_any_strobe;
    logic [2:0]      w_set;
    logic [2:0]      w_clr;
    logic [1:0]      w_level;

    assign w_accept     = r_we_q & ~nLSPWE;
    assign w_any_strobe = ~r_nuds | ~r_nlds;
    assign w_set        = {1'b0, TIMER_IRQ & ~r_tirq_q, VBL_IRQ};
    assign w_clr        = (r_acc && r_addr == 3'd6 && !r_nlds)
                        ? {r_data[0], r_data[1], r_data[2]}
                        : 3'b000;

    // Capture one write per nLSPWE falling edge, with its address, lanes and data
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_we_q <= 1'b0;
            r_acc  <= 1'b0;
            r_addr <= 3'd0;
            r_data <= 16'd0;
            r_nuds <= 1'b1;
            r_nlds <= 1'b1;
        end else begin
            r_we_q <= nLSPWE;
            r_acc  <= w_accept;
            if (w_accept) begin
                r_addr <= M68K_ADDR;
                r_data <= M68K_DATA;
                r_nuds <= M68K_nUDS;
                r_nlds <= M68K_nLDS;
            end
        end
    end

    // One-cycle timer load strobes, issued the cycle after the accept
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_wr_hi <= 1'b0;
            r_wr_lo <= 1'b0;
        end else begin
            r_wr_hi <= r_acc && r_addr == 3'd4 && w_any_strobe;
            r_wr_lo <= r_acc && r_addr == 3'd5 && w_any_strobe;
        end
    end

    // Mode and stop registers with per-byte-lane updates
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_mode     <= 3'd0;
            r_irq_en   <= 1'b0;
            r_aa_dis   <= 1'b0;
            r_aa_speed <= '0;
            r_stop     <= 1'b0;
        end else if (r_acc) begin
            if (r_addr == 3'd3) begin
                if (!r_nlds) begin
                    r_mode   <= r_data[7:5];
                    r_irq_en <= r_data[4];
                    r_aa_dis <= r_data[3];
                end
                if (!r_nuds) begin
                    r_aa_speed <= AA_W'(r_data[15:8]);
                end
            end
            if (r_addr == 3'd7 && !r_nlds) begin
                r_stop <= r_data[0];
            end
        end
    end

    // Priority level of the highest pending source
    always_comb begin
        w_level = 2'd0;
        if (r_pend[2]) begin
            w_level = 2'd3;
        end else if (r_pend[1]) begin
            w_level = 2'd2;
        end else if (r_pend[0]) begin
            w_level = 2'd1;
        end
    end

    // Pending latch (set beats ack) and registered active-low priority
    always_ff @(posedge CLK) begin
        if (!nRESETP) begin
            r_pend   <= {IRQ_RST, 2'b00};
            r_tirq_q <= 1'b0;
            r_nipl   <= 3'b111;
        end else begin
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_tirq_q <= TIMER_IRQ;
            r_nipl   <= ~{1'b0, w_level};
        end
    end

`ifdef LSPC_IRQ_READBACK_EN
    // Combinational register readback
    always_comb begin
        RD_DATA = 16'd0;
        case (M68K_ADDR)
            3'd6:    RD_DATA = {13'd0, r_pend};
            3'd3:    RD_DATA = 16'({r_aa_speed, r_mode, r_irq_en,
                                    r_aa_dis, 3'd0});
            default: RD_DATA = 16'd0;
        endcase
    end
`endif

    assign WR_TIMER_HIGH = r_wr_hi;
    assign WR_TIMER_LOW  = r_wr_lo;
    assign TIMER_MODE    = r_mode;
    assign TIMER_IRQ_EN  = r_irq_en;
    assign AA_DISABLE    = r_aa_dis;
    assign AA_SPEED      = r_aa_speed;
    assign TIMER_STOP    = r_stop;
    assign IRQ_PEND      = r_pend;
    assign nIPL          = r_nipl;

endmodule
